// File: rtl/temp_reg_bank.sv
// temp_reg_bank
//   Multi-entry staging register between the PIM compute array and the
//   move/transfer datapath. Holds DEPTH words of N bits, each loadable from
//   the PIM result path or the MOV path, with a per-entry valid bit, an
//   occupancy count and a registered read port with a one-cycle acknowledge.
//
// Parameters
//   N      word width in bits (>=1)
//   DEPTH  number of entries (>=2, any value)
//   AW     address width, derived from DEPTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   D          PIM result data
//   pim_addr   PIM write address
//   PIM_load   PIM write strobe
//   MOV_in     move-path data
//   mov_addr   MOV write address
//   Mov_load   MOV write strobe
//   clr        synchronous clear of all valid bits (highest priority)
//   rd_en      read request
//   rd_addr    read address
//   Q          registered read data
//   Q_valid    valid bit of the entry read, registered with Q
//   rd_ack     one-cycle pulse marking Q/Q_valid updated
//   valid_vec  per-entry valid bits
//   count      number of valid entries (0..DEPTH)

module temp_reg_bank #(
  parameter int N     = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     D,
  input  logic [AW-1:0]    pim_addr,
  input  logic             PIM_load,
  input  logic [N-1:0]     MOV_in,
  input  logic [AW-1:0]    mov_addr,
  input  logic             Mov_load,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [N-1:0]     Q,
  output logic             Q_valid,
  output logic             rd_ack,
  output logic [DEPTH-1:0] valid_vec,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [N-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] valid_nxt;
  logic [AW:0]      count_nxt;
  logic             pim_we;
  logic             mov_we;
  logic             rd_in_range;

  // Address decode: out-of-range addresses (possible when DEPTH is not a
  // power of two) never write and read back as zero.
  always_comb begin
    pim_we      = 1'b0;
    mov_we      = 1'b0;
    rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    if (!clr) begin
      pim_we = PIM_load && ({1'b0, pim_addr} < DEPTH_W);
      // PIM wins a same-address collision; the MOV write is dropped.
      mov_we = Mov_load && ({1'b0, mov_addr} < DEPTH_W) &&
               !(PIM_load && (mov_addr == pim_addr));
    end
  end

  // Next-state valid bits and their popcount; count is registered from the
  // next-state vector so it always matches valid_vec in the same cycle.
  always_comb begin
    valid_nxt = valid_vec;
    if (clr) begin
      valid_nxt = '0;
    end else begin
      if (pim_we) valid_nxt[pim_addr] = 1'b1;
      if (mov_we) valid_nxt[mov_addr] = 1'b1;
    end
    count_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_nxt = count_nxt + (AW+1)'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_vec <= '0;
      count     <= '0;
    end else begin
      valid_vec <= valid_nxt;
      count     <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pim_we) mem[pim_addr] <= D;
      if (mov_we) mem[mov_addr] <= MOV_in;
    end
  end

  // Read port samples the array before this edge's writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q       <= '0;
      Q_valid <= 1'b0;
      rd_ack  <= 1'b0;
    end else begin
      rd_ack <= rd_en;
      if (rd_en) begin
        if (rd_in_range) begin
          Q       <= mem[rd_addr];
          Q_valid <= valid_vec[rd_addr];
        end else begin
          Q       <= '0;
          Q_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_reg_bank.sv
module tb_temp_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;

  // DEPTH=8 instance
  logic [9:0] D, MOV_in, Q;
  logic [2:0] pim_addr, mov_addr, rd_addr;
  logic       PIM_load, Mov_load, clr, rd_en, Q_valid, rd_ack;
  logic [7:0] valid_vec;
  logic [3:0] count;

  // DEPTH=6 instance
  logic [9:0] D6, MOV_in6, Q6;
  logic [2:0] pim_addr6, mov_addr6, rd_addr6;
  logic       PIM_load6, Mov_load6, clr6, rd_en6, Q_valid6, rd_ack6;
  logic [5:0] valid_vec6;
  logic [3:0] count6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  temp_reg_bank #(.N(10), .DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .D(D), .pim_addr(pim_addr), .PIM_load(PIM_load),
    .MOV_in(MOV_in), .mov_addr(mov_addr), .Mov_load(Mov_load), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .Q(Q), .Q_valid(Q_valid), .rd_ack(rd_ack),
    .valid_vec(valid_vec), .count(count)
  );

  temp_reg_bank #(.N(10), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .D(D6), .pim_addr(pim_addr6), .PIM_load(PIM_load6),
    .MOV_in(MOV_in6), .mov_addr(mov_addr6), .Mov_load(Mov_load6), .clr(clr6),
    .rd_en(rd_en6), .rd_addr(rd_addr6), .Q(Q6), .Q_valid(Q_valid6), .rd_ack(rd_ack6),
    .valid_vec(valid_vec6), .count(count6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    PIM_load = 0; Mov_load = 0; clr = 0; rd_en = 0;
    PIM_load6 = 0; Mov_load6 = 0; clr6 = 0; rd_en6 = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    D = '0; MOV_in = '0; pim_addr = '0; mov_addr = '0; rd_addr = '0;
    D6 = '0; MOV_in6 = '0; pim_addr6 = '0; mov_addr6 = '0; rd_addr6 = '0;
    idle();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid_vec", 32'(valid_vec), 0);
    chk("rst_Q", 32'(Q), 0);
    chk("rst_Q_valid", 32'(Q_valid), 0);
    chk("rst_rd_ack", 32'(rd_ack), 0);

    // Basic write / read
    PIM_load = 1; pim_addr = 2; D = 10'h155;
    tick(); idle();
    chk("wr2_valid_vec", 32'(valid_vec), 32'h04);
    chk("wr2_count", 32'(count), 1);
    rd_en = 1; rd_addr = 2;
    tick(); idle();
    chk("rd2_Q", 32'(Q), 32'h155);
    chk("rd2_Q_valid", 32'(Q_valid), 1);
    chk("rd2_ack", 32'(rd_ack), 1);
    tick();
    chk("idle_ack_low", 32'(rd_ack), 0);
    chk("idle_Q_hold", 32'(Q), 32'h155);

    // Same-address collision: PIM wins
    PIM_load = 1; pim_addr = 5; D = 10'h0AA;
    Mov_load = 1; mov_addr = 5; MOV_in = 10'h3FF;
    tick(); idle();
    chk("coll_count", 32'(count), 2);
    chk("coll_valid_vec", 32'(valid_vec), 32'h24);
    rd_en = 1; rd_addr = 5;
    tick(); idle();
    chk("coll_Q", 32'(Q), 32'h0AA);

    // Dual write to different addresses
    PIM_load = 1; pim_addr = 0; D = 10'h0AA;
    Mov_load = 1; mov_addr = 6; MOV_in = 10'h3FF;
    tick(); idle();
    chk("dual_count", 32'(count), 4);
    chk("dual_valid_vec", 32'(valid_vec), 32'h65);
    rd_en = 1; rd_addr = 6;
    tick();
    chk("dual_Q6", 32'(Q), 32'h3FF);
    rd_addr = 0;
    tick(); idle();
    chk("b2b_Q0", 32'(Q), 32'h0AA);
    chk("b2b_ack", 32'(rd_ack), 1);

    // Read-before-write
    PIM_load = 1; pim_addr = 3; D = 10'h011;
    tick(); idle();
    chk("rbw_count", 32'(count), 5);
    PIM_load = 1; pim_addr = 3; D = 10'h022;
    rd_en = 1; rd_addr = 3;
    tick(); idle();
    chk("rbw_old_Q", 32'(Q), 32'h011);
    chk("rewrite_count", 32'(count), 5);
    rd_en = 1; rd_addr = 3;
    tick(); idle();
    chk("rbw_new_Q", 32'(Q), 32'h022);

    // Fill all entries, MOV alone on entry 7
    PIM_load = 1; pim_addr = 1; D = 10'h001;
    Mov_load = 1; mov_addr = 7; MOV_in = 10'h007;
    tick(); idle();
    chk("fill7_valid_vec", 32'(valid_vec), 32'hEF);
    PIM_load = 1; pim_addr = 4; D = 10'h004;
    tick(); idle();
    chk("full_count", 32'(count), 8);
    chk("full_valid_vec", 32'(valid_vec), 32'hFF);
    rd_en = 1; rd_addr = 7;
    tick(); idle();
    chk("mov7_Q", 32'(Q), 32'h007);

    // clr beats a simultaneous PIM load
    clr = 1; PIM_load = 1; pim_addr = 4; D = 10'h2AA;
    tick(); idle();
    chk("clr_valid_vec", 32'(valid_vec), 0);
    chk("clr_count", 32'(count), 0);
    rd_en = 1; rd_addr = 4;
    tick(); idle();
    chk("clr_Q_valid", 32'(Q_valid), 0);
    chk("clr_rd_ack", 32'(rd_ack), 1);

    // Asynchronous reset mid-stream with a write and a read pending
    PIM_load = 1; pim_addr = 2; D = 10'h0F0;
    tick(); idle();
    rd_en = 1; rd_addr = 2;
    tick();
    chk("pre_rst_count", 32'(count), 1);
    chk("pre_rst_Q", 32'(Q), 32'h0F0);
    PIM_load = 1; pim_addr = 3; D = 10'h033;
    #2 rst_n = 1'b0;
    #1;
    chk("async_Q", 32'(Q), 0);
    chk("async_Q_valid", 32'(Q_valid), 0);
    chk("async_rd_ack", 32'(rd_ack), 0);
    chk("async_valid_vec", 32'(valid_vec), 0);
    chk("async_count", 32'(count), 0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_ack", 32'(rd_ack), 0);
    rd_en = 1; rd_addr = 2;
    tick(); idle();
    chk("post_rst_Q", 32'(Q), 0);
    chk("post_rst_Q_valid", 32'(Q_valid), 0);

    // DEPTH=6: out-of-range addresses
    PIM_load6 = 1; pim_addr6 = 5; D6 = 10'h123;
    tick(); idle();
    chk("d6_count", 32'(count6), 1);
    chk("d6_valid_vec", 32'(valid_vec6), 32'h20);
    PIM_load6 = 1; pim_addr6 = 7; D6 = 10'h3FF;
    Mov_load6 = 1; mov_addr6 = 6; MOV_in6 = 10'h001;
    tick(); idle();
    chk("d6_oor_count", 32'(count6), 1);
    chk("d6_oor_valid_vec", 32'(valid_vec6), 32'h20);
    rd_en6 = 1; rd_addr6 = 5;
    tick();
    chk("d6_rd5_Q", 32'(Q6), 32'h123);
    rd_addr6 = 7;
    tick(); idle();
    chk("d6_rd7_Q", 32'(Q6), 0);
    chk("d6_rd7_Q_valid", 32'(Q_valid6), 0);
    chk("d6_rd7_ack", 32'(rd_ack6), 1);
    rd_en6 = 1; rd_addr6 = 1;
    tick(); idle();
    chk("d6_rd1_Q", 32'(Q6), 0);
    chk("d6_rd1_Q_valid", 32'(Q_valid6), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
